// File: rtl/cla_multiword_sequencer_pkg.sv
// Shared constants, state encoding and limb helper for the multi-word CLA sequencer.
// Optional subtraction is built only with CLA_SEQ_SUB_EN defined.
package cla_seq_pkg;

   localparam int LIMB_W    = 16;
   localparam int MAX_WORDS = 8;
   localparam int MAX_W     = LIMB_W * MAX_WORDS;

   typedef logic [LIMB_W-1:0] limb_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Operands are zero-extended to MAX_W so one helper serves every WORDS setting.
   function automatic limb_t limb_sel(input logic [MAX_W-1:0] v, input logic [2:0] idx);
      return v[idx*LIMB_W +: LIMB_W];
   endfunction

endpackage

// File: rtl/cla_multiword_sequencer_if.sv
// Operand/result handshake bundle between a requester and the multi-word CLA sequencer.
// The sub control exists only with CLA_SEQ_SUB_EN defined.
interface cla_multiword_sequencer_if #(
   parameter int WORDS = 4
);
   localparam int N = 16 * WORDS;

   logic         start_valid;
   logic         start_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
`ifdef CLA_SEQ_SUB_EN
   logic         sub;
`endif
   logic         result_valid;
   logic         result_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         overflow;

   modport master (
      output start_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
      output sub,
`endif
      output result_ready,
      input  start_ready, result_valid, sum, cout, overflow
   );

   modport slave (
      input  start_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
      input  sub,
`endif
      input  result_ready,
      output start_ready, result_valid, sum, cout, overflow
   );

endinterface

// File: rtl/cla_multiword_sequencer_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// feeding a second-level carry network.
module carry_lookahead_16bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] s_o,
   output logic        cout_o
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  pg;
   logic [4:0]  cg;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   always_comb begin
      gg = '0;
      pg = '0;
      cg = '0;
      c  = '0;
      for (int k = 0; k < 4; k++) begin
         gg[k] = 1'b0;
         pg[k] = 1'b1;
         for (int i = 0; i < 4; i++) begin
            gg[k] = g[4*k+i] | (p[4*k+i] & gg[k]);
            pg[k] = pg[k] & p[4*k+i];
         end
      end
      cg[0] = cin_i;
      for (int k = 0; k < 4; k++) begin
         cg[k+1] = gg[k] | (pg[k] & cg[k]);
      end
      // Bit carries inside each group start from the lookahead group carry.
      for (int k = 0; k < 4; k++) begin
         c[4*k] = cg[k];
         for (int i = 0; i < 3; i++) begin
            c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
         end
      end
   end

   assign s_o    = p ^ c;
   assign cout_o = cg[4];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Sequences a WORDS x 16-bit add (or subtract with CLA_SEQ_SUB_EN) through one shared
// 16-bit CLA, LSB limb first, with the inter-limb carry held in a register.
//
// state   | meaning
// IDLE    | waiting for operands, start_ready high
// RUN     | one limb per cycle through the adder, carry chained in c_q
// DONE    | result held, waiting for result_ready
module cla_multiword_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   cla_multiword_sequencer_if.slave bus
);

   localparam int N     = LIMB_W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             c_q, c_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [N-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   limb_t add_a;
   limb_t add_b;
   limb_t add_s;
   logic  add_co;
   logic  accept;
   logic  last_limb;

   assign add_a = limb_sel(MAX_W'(a_q), 3'(idx_q));
   assign add_b = limb_sel(MAX_W'(b_q), 3'(idx_q));

   carry_lookahead_16bit u_cla (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (c_q),
      .s_o    (add_s),
      .cout_o (add_co)
   );

   assign accept    = bus.start_valid && (state_q == ST_IDLE);
   assign last_limb = (idx_q == IDX_W'(WORDS - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d   = bus.a;
`ifdef CLA_SEQ_SUB_EN
               b_d   = bus.sub ? ~bus.b : bus.b;
               c_d   = bus.sub ? 1'b1 : bus.cin;
`else
               b_d   = bus.b;
               c_d   = bus.cin;
`endif
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[i*LIMB_W +: LIMB_W] = add_s;
               end
            end
            c_d   = add_co;
            idx_d = idx_q + 1'b1;
            if (last_limb) begin
               cout_d  = add_co;
               // Signed overflow from operand signs and the fresh MSB limb result.
               ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_s[LIMB_W-1] != a_q[N-1]);
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.result_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         c_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.start_ready  = (state_q == ST_IDLE) && !rst;
   assign bus.result_valid = (state_q == ST_DONE);
   assign bus.sum          = sum_q;
   assign bus.cout         = cout_q;
   assign bus.overflow     = ovf_q;

endmodule
